// File: rtl/pio_pwm_pkg.sv
// Shared definitions for the two-channel PIO PWM fader.
// Holds the per-channel state encoding, the Avalon register map and
// the register reset values.
package pio_pwm_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } ch_state_t;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_DUTY0  = 2'd1;
  localparam logic [1:0] ADDR_DUTY1  = 2'd2;
  localparam logic [1:0] ADDR_STEP   = 2'd3;

  localparam int unsigned PERIOD_RST = 1000;
  localparam int unsigned STEP_RST   = 1;

endpackage

// File: rtl/pio_pwm_channel.sv
// One fader channel: ramps its level toward goal (duty when enabled,
// else zero) by STEP once per PWM period and drives a registered PWM bit.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            on request for this channel
//   duty, step        programmed target and ramp increment
//   cnt, period_end   shared period counter and its wrap pulse
//   run               low while PERIOD is 0 (forces pwm low)
//   level             current duty level
//   state             registered OFF/RISE/ON/FALL decode
//   pwm               registered PWM output
module pio_pwm_channel
  import pio_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] step,
  input  logic [CNT_W-1:0] cnt,
  input  logic             period_end,
  input  logic             run,
  output logic [CNT_W-1:0] level,
  output ch_state_t        state,
  output logic             pwm
);

  logic [CNT_W-1:0] goal;
  logic [CNT_W-1:0] level_nxt;
  logic [CNT_W:0]   sum_up;
  logic [CNT_W:0]   fall_lim;
  ch_state_t        state_nxt;

  always_comb begin
    goal      = enable ? duty : '0;
    // One extra bit keeps both the rising sum and the falling threshold from wrapping.
    sum_up    = {1'b0, level} + {1'b0, step};
    fall_lim  = {1'b0, goal} + {1'b0, step};
    level_nxt = level;
    if (step == '0) begin
      level_nxt = goal;
    end else if (level < goal) begin
      level_nxt = (sum_up > {1'b0, goal}) ? goal : sum_up[CNT_W-1:0];
    end else if (level > goal) begin
      level_nxt = ({1'b0, level} > fall_lim) ? (level - step) : goal;
    end
  end

  always_comb begin
    if (level < goal)       state_nxt = ST_RISE;
    else if (level > goal)  state_nxt = ST_FALL;
    else if (level == '0)   state_nxt = ST_OFF;
    else                    state_nxt = ST_ON;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      state <= ST_OFF;
      pwm   <= 1'b0;
    end else begin
      if (period_end) level <= level_nxt;
      state <= state_nxt;
      pwm   <= run && (cnt < level);
    end
  end

endmodule

// File: rtl/pio_pwm_fader.sv
// Two-channel PWM fader fed by the LED PIO out_port. Contains the
// zero-wait-state Avalon-MM register file, the combinational read mux
// and the shared period counter; ramp logic lives in pio_pwm_channel.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   enable[1:0]                         per-channel on request from the PIO
//   address, chipselect, write_n,
//   writedata, readdata                 Avalon-MM slave (0 PERIOD, 1 DUTY0,
//                                       2 DUTY1, 3 STEP + channel states)
//   pwm_out[1:0]                        registered PWM outputs
module pio_pwm_fader #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERIOD_RST = pio_pwm_pkg::PERIOD_RST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  enable,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pwm_out
);

  import pio_pwm_pkg::*;

  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] duty0_q;
  logic [CNT_W-1:0] duty1_q;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] wdata;
  logic             wr;
  logic             period_wr;
  logic             period_end;
  logic             run;
  logic [CNT_W-1:0] level0;
  logic [CNT_W-1:0] level1;
  ch_state_t        state0;
  ch_state_t        state1;
  logic             unused_bits;

  assign wr        = chipselect && !write_n;
  assign wdata     = writedata[CNT_W-1:0];
  assign period_wr = wr && (address == ADDR_PERIOD);
  assign run       = (period_q != '0);
  // A PERIOD write restarts the count, so it must not also count as a wrap.
  assign period_end = run && (cnt_q == period_q) && !period_wr;

  // Levels are observation points only; upper write bits are ignored.
  assign unused_bits = ^{level0, level1, writedata[31:CNT_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= CNT_W'(PERIOD_RST);
      duty0_q  <= '0;
      duty1_q  <= '0;
      step_q   <= CNT_W'(STEP_RST);
      cnt_q    <= '0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_PERIOD: period_q <= wdata;
          ADDR_DUTY0:  duty0_q  <= wdata;
          ADDR_DUTY1:  duty1_q  <= wdata;
          ADDR_STEP:   step_q   <= wdata;
        endcase
      end
      if (period_wr || (cnt_q >= period_q)) cnt_q <= '0;
      else                                  cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_PERIOD: readdata[CNT_W-1:0] = period_q;
      ADDR_DUTY0:  readdata[CNT_W-1:0] = duty0_q;
      ADDR_DUTY1:  readdata[CNT_W-1:0] = duty1_q;
      ADDR_STEP: begin
        readdata[CNT_W-1:0]  = step_q;
        readdata[CNT_W +: 4] = {state1, state0};
      end
    endcase
  end

  pio_pwm_channel #(.CNT_W(CNT_W)) u_ch0 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable[0]),
    .duty       (duty0_q),
    .step       (step_q),
    .cnt        (cnt_q),
    .period_end (period_end),
    .run        (run),
    .level      (level0),
    .state      (state0),
    .pwm        (pwm_out[0])
  );

  pio_pwm_channel #(.CNT_W(CNT_W)) u_ch1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable[1]),
    .duty       (duty1_q),
    .step       (step_q),
    .cnt        (cnt_q),
    .period_end (period_end),
    .run        (run),
    .level      (level1),
    .state      (state1),
    .pwm        (pwm_out[1])
  );

endmodule

// File: tb/tb_pio_pwm_fader.sv
// Directed self-checking bench for pio_pwm_fader: reset values, ramp up,
// ramp down with saturation, STEP=0 jump and no-wrap falling step,
// PERIOD=0 freeze, PERIOD restart, DUTY write on period_end, mid-ramp reset.
module tb_pio_pwm_fader;

  logic        clk;
  logic        reset;
  logic [1:0]  enable;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pwm_out;

  int n_cmp;
  int n_err;

  pio_pwm_fader #(.CNT_W(16), .PERIOD_RST(1000)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwm_out    (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  function automatic logic [15:0] lvl(input int ch);
    return (ch == 0) ? dut.u_ch0.level : dut.u_ch1.level;
  endfunction

  // Waits for the channel level to change; returns new value and cycles waited.
  task automatic wait_lvl(input int ch, output logic [15:0] v, output int n);
    logic [15:0] old;
    old = lvl(ch);
    n = 0;
    while (lvl(ch) == old && n < 200) begin
      tick();
      n++;
    end
    v = lvl(ch);
    if (v == old) check("level_change_timeout", 32'(n), 32'(0));
  endtask

  // Counts high cycles of pwm_out[ch] over len samples.
  task automatic count_hi(input int ch, input int len, output int hi);
    hi = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (pwm_out[ch]) hi++;
    end
  endtask

  initial begin
    logic [15:0] v;
    int          n;
    int          hi;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; enable = 2'b00; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // Reset
    tick(); tick();
    rd("rst_period_during_reset", 2'd0, 32'd1000);
    reset = 1'b0;
    check("rst_pwm", 32'(pwm_out), 32'h0);
    rd("rst_period", 2'd0, 32'd1000);
    rd("rst_status", 2'd3, 32'h0000_0001);

    // Ramp up: PERIOD 9, STEP 2, DUTY0 6
    wr(2'd0, 32'd9);
    wr(2'd3, 32'd2);
    wr(2'd1, 32'd6);
    enable = 2'b01;
    tick();
    rd("up_state_rise", 2'd3, 32'h0001_0002);
    wait_lvl(0, v, n);
    check("up_lvl_2", 32'(v), 32'd2);
    wait_lvl(0, v, n);
    check("up_lvl_4", 32'(v), 32'd4);
    check("up_gap_4", 32'(n), 32'd10);
    wait_lvl(0, v, n);
    check("up_lvl_6", 32'(v), 32'd6);
    check("up_gap_6", 32'(n), 32'd10);
    tick();
    rd("up_state_on", 2'd3, 32'h0002_0002);
    count_hi(0, 10, hi);
    check("up_pwm_duty", 32'(hi), 32'd6);

    // Ramp down with saturation
    wr(2'd1, 32'd5);
    wait_lvl(0, v, n);
    check("dn_lvl_5", 32'(v), 32'd5);
    enable = 2'b00;
    tick();
    rd("dn_state_fall", 2'd3, 32'h0003_0002);
    wait_lvl(0, v, n);
    check("dn_lvl_3", 32'(v), 32'd3);
    wait_lvl(0, v, n);
    check("dn_lvl_1", 32'(v), 32'd1);
    wait_lvl(0, v, n);
    check("dn_lvl_0", 32'(v), 32'd0);
    tick();
    rd("dn_state_off", 2'd3, 32'h0000_0002);
    count_hi(0, 10, hi);
    check("dn_pwm_low", 32'(hi), 32'd0);

    // Jump (STEP 0) to full scale, then no-wrap falling step
    wr(2'd3, 32'd0);
    wr(2'd2, 32'h0000_FFFF);
    wr(2'd0, 32'd20);
    enable = 2'b10;
    wait_lvl(1, v, n);
    check("jmp_lvl_ffff", 32'(v), 32'h0000_FFFF);
    check("jmp_latency", 32'(n), 32'd21);
    tick();
    rd("jmp_state_on", 2'd3, 32'h0008_0000);
    count_hi(1, 21, hi);
    check("jmp_pwm_const_hi", 32'(hi), 32'd21);
    wr(2'd3, 32'h0000_FFFF);
    wr(2'd2, 32'h0000_FFFE);
    wait_lvl(1, v, n);
    check("ovf_lvl_fffe", 32'(v), 32'h0000_FFFE);

    // PERIOD = 0 freezes levels and forces pwm low
    wr(2'd0, 32'd0);
    enable = 2'b00;
    tick(); tick();
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pwm_out != 2'b00) hi++;
    end
    check("p0_pwm_low", 32'(hi), 32'd0);
    check("p0_lvl_frozen", 32'(lvl(1)), 32'h0000_FFFE);
    rd("p0_state_fall", 2'd3, 32'h000C_FFFF);

    // PERIOD write mid-count restarts cnt
    wr(2'd0, 32'd9);
    repeat (5) tick();
    wr(2'd0, 32'd9);
    wait_lvl(1, v, n);
    check("restart_gap", 32'(n), 32'd10);
    check("restart_lvl_0", 32'(v), 32'd0);

    // DUTY write coinciding with period_end steps toward the old goal
    wr(2'd3, 32'd2);
    wr(2'd1, 32'd6);
    wr(2'd0, 32'd9);
    enable = 2'b01;
    repeat (9) tick();
    wr(2'd1, 32'd0);
    check("coinc_old_goal", 32'(lvl(0)), 32'd2);
    rd("coinc_duty0", 2'd1, 32'd0);
    wait_lvl(0, v, n);
    check("coinc_new_goal", 32'(v), 32'd0);
    check("coinc_gap", 32'(n), 32'd10);

    // Reset mid-ramp
    wr(2'd1, 32'd8);
    wait_lvl(0, v, n);
    check("mr_lvl_2", 32'(v), 32'd2);
    wait_lvl(0, v, n);
    check("mr_lvl_4", 32'(v), 32'd4);
    tick();
    rd("mr_state_rise", 2'd3, 32'h0001_0002);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_lvl0_zero", 32'(lvl(0)), 32'd0);
    check("mr_pwm_zero", 32'(pwm_out), 32'h0);
    rd("mr_status", 2'd3, 32'h0000_0001);
    rd("mr_period", 2'd0, 32'd1000);
    rd("mr_duty0", 2'd1, 32'd0);
    rd("mr_duty1", 2'd2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_pwm_fader.md
# pio_pwm_fader

Two-channel PWM fader placed directly downstream of the 2-bit LED PIO output port. It consumes the PIO's `out_port` bits as per-channel on/off requests. Each channel ramps its PWM duty up to a programmed target, or back down to zero, in fixed steps once per PWM period. Period, targets and step size are programmed by the Nios II through its own zero-wait-state Avalon-MM slave.

## Interface
Parameters:
- `CNT_W`, 16: width of the period counter, duty registers and step register.
- `PERIOD_RST`, 1000: reset value of the PERIOD register.

Ports:
- `clk`, in, 1: system clock. Single clock domain; `enable` is already synchronous to it.
- `reset`, in, 1: synchronous reset, active-high.
- `enable`, in, 2: per-channel on request, driven by the PIO `out_port`.
- `address`, in, 2: register select. 0 = PERIOD, 1 = DUTY0, 2 = DUTY1, 3 = STEP/STATUS.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data. Only bits `[CNT_W-1:0]` are used.
- `readdata`, out, 32: combinational read data.
- `pwm_out`, out, 2: registered PWM outputs to the LED pins.

## Operation
- Write decode: a write occurs when `chipselect && !write_n`. It updates the addressed register from `writedata[15:0]` on the next clock edge.
- Reset values: PERIOD = `PERIOD_RST`, DUTY0 = DUTY1 = 0, STEP = 1.
- Read map:
  - Addresses 0–2 return `{16'b0, reg}`.
  - Address 3 returns `{12'b0, state1[1:0], state0[1:0], STEP}`.
- Period counter `cnt`:
  - Counts 0..PERIOD, then wraps to 0.
  - `period_end` pulses for the one cycle where `cnt == PERIOD`.
  - A write to PERIOD forces `cnt` to 0 on the same edge the new value loads. No `period_end` is generated by that write.
  - PERIOD = 0: `cnt` holds 0, `period_end` never fires, levels freeze and `pwm_out` = 0.
- Per-channel level:
  - `goal = enable[i] ? DUTYi : 0`.
  - `level[i]` changes only on `period_end`, so PWM is glitch-free.
  - Rising: `level = min(level + STEP, goal)`. Use a 17-bit sum so there is no wrap.
  - Falling: `level = (level > goal + STEP) ? level - STEP : goal`. Use 17-bit compare.
  - STEP = 0 means jump: `level = goal` on the next `period_end`.
- Per-channel state machine, 2-bit encoding: OFF = 0, RISE = 1, ON = 2, FALL = 3. Evaluated every cycle from `level` and `goal`:
  - OFF: `level == 0` and `goal == 0`.
  - RISE: `level < goal`.
  - ON: `level == goal != 0`.
  - FALL: `level > goal`.
- Output: `pwm_out[i] <= (cnt < level[i])`. A level greater than PERIOD gives constant high, except at `cnt` values ≥ level, which never occur.
- Simultaneous events:
  - DUTY write or `enable` change in the same cycle as `period_end`: the step uses the old `goal`. The new `goal` takes effect at the next `period_end`.
  - Channels are fully independent. Both may step on the same `period_end`.
- Reset mid-ramp: on the next edge, all levels return to 0, states to OFF, `cnt` to 0 and `pwm_out` to 0.

## Timing
- `readdata`: combinational, zero wait states. It reflects a register write from the cycle after that write.
- `enable` change to state change: at most 1 cycle (state is a registered decode).
- `enable` change to first level step: at the next `period_end`, i.e. within PERIOD+1 cycles.
- `level` change to `pwm_out`: 1 cycle of pipeline latency.
- Full ramp 0 → D: `ceil(D/STEP)` periods, each of PERIOD+1 cycles.
- All outputs are 0 during reset. `readdata` during reset shows the reset register values: with address 0 it reads 1000.

## Structure
- Shared package `pio_pwm_pkg` holds:
  - State encodings OFF/RISE/ON/FALL.
  - Register address constants.
  - Reset values PERIOD_RST and STEP_RST.
- Sub-module `pio_pwm_channel`, instanced ×2. Inputs: `enable`, `duty`, `step`, `cnt`, `period_end`. Outputs: `level`, `state`, `pwm`. It contains the ramp arithmetic and the state register.
- Top level contains the Avalon register file, read mux and period counter.

## Test plan
- Reset: assert `reset` for 2 cycles. Then `pwm_out` = 00, a read at address 0 returns 1000, and a read at address 3 returns 0x00000001.
- Ramp up: PERIOD = 9, STEP = 2, DUTY0 = 6, `enable` = 01.
  - State0 = RISE.
  - `level0` goes 2, 4, 6 at successive `period_end`s, 10 cycles apart, then state0 = ON.
  - `pwm_out[0]` is high for 6 of every 10 cycles.
- Ramp down with saturation: from the previous ON, DUTY0 = 5, then `enable` = 00.
  - `level0` goes 5, 3, 1, 0 (saturating at 0).
  - State0 goes FALL then OFF, and `pwm_out[0]` is held low.
- Jump and overflow: STEP = 0, DUTY1 = 0xFFFF, PERIOD = 20, `enable[1]` = 1.
  - `level1` = 0xFFFF after one period and `pwm_out[1]` is constant high.
  - Then STEP = 0xFFFF with DUTY1 = 0xFFFE: the falling step saturates at 0xFFFE with no wrap.
- Boundaries:
  - PERIOD = 0: `pwm_out` = 00 and levels are frozen.
  - A PERIOD write in mid-count restarts `cnt` from 0.
  - A DUTY write coinciding with `period_end` steps toward the old `goal` first.
- Reset mid-ramp: during a RISE with `level0` = 4, pulse `reset` for 1 cycle. Next cycle `level0` = 0, state0 = OFF, `pwm_out` = 00, and all registers are back at reset values.
